// File: rtl/pipe_adder_if.sv
// Handshake and operand bus for pipe_adder.
// Optional saturation input exists only when PIPE_ADDER_SAT_EN is defined.
`timescale 1ns/1ps
interface pipe_adder_if #(
    parameter int unsigned N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         sub;
`ifdef PIPE_ADDER_SAT_EN
    logic         sat;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         neg;

    // Producer/consumer side
    modport master (
        output in_valid, a, b, cin, sub,
`ifdef PIPE_ADDER_SAT_EN
        output sat,
`endif
        output out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero, neg
    );

    // Adder side
    modport slave (
        input  in_valid, a, b, cin, sub,
`ifdef PIPE_ADDER_SAT_EN
        input  sat,
`endif
        input  out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero, neg
    );
endinterface

// File: rtl/pipe_adder.sv
// Pipelined N-bit adder/subtractor with valid/ready handshake and NZCV-style flags.
// The carry chain is cut into STAGES segments of W = N/STAGES bits; stage k adds
// slice k with the carry registered by stage k-1. The last stage registers sum
// and flags. Define PIPE_ADDER_SAT_EN to add the signed-saturation input.
`timescale 1ns/1ps
module pipe_adder #(
    parameter int unsigned N      = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    pipe_adder_if.slave  bus
);
    localparam int unsigned W  = N / STAGES;
    localparam int unsigned L  = STAGES - 1;
    localparam int unsigned NQ = (STAGES > 1) ? STAGES - 1 : 1;

    // Elaboration-time parameter checks
    if (STAGES < 1 || STAGES > N) begin : g_bad_stages
        $error("pipe_adder: STAGES must be in 1..N");
    end
    if ((N % STAGES) != 0) begin : g_bad_split
        $error("pipe_adder: N must be a multiple of STAGES");
    end

    // Stage inputs (index k feeds stage k)
    logic [N-1:0] si_a [STAGES];
    logic [N-1:0] si_b [STAGES];
    logic [N-1:0] si_s [STAGES];
    logic         si_c [STAGES];
    logic         si_v [STAGES];

    // Stage combinational results
    logic [N-1:0] so_s [STAGES];
    logic         so_c [STAGES];

    // Inter-stage registers (stages 0..STAGES-2)
    logic [N-1:0] q_a [NQ];
    logic [N-1:0] q_b [NQ];
    logic [N-1:0] q_s [NQ];
    logic         q_c [NQ];
    logic         q_v [STAGES];

`ifdef PIPE_ADDER_SAT_EN
    logic         si_sat [STAGES];
    logic         q_sat  [NQ];
`endif

    // Last-stage result and output registers
    logic [N-1:0] res_c;
    logic         ovf_c;
    logic [N-1:0] r_sum;
    logic         r_cout;
    logic         r_ovf;
    logic         r_zero;
    logic         r_neg;

    logic         adv_c;

    // Global advance: move everything unless a held result blocks the output
    assign adv_c = !q_v[L] || bus.out_ready;

    // Per-stage slice adder; stage 0 takes the bus directly with b pre-inverted for sub
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [W:0]   add_c;
        logic [N-1:0] nxt_s;

        if (k == 0) begin : g_head
            assign si_a[k] = bus.a;
            assign si_b[k] = bus.sub ? ~bus.b : bus.b;
            assign si_s[k] = '0;
            assign si_c[k] = bus.sub | bus.cin;
            assign si_v[k] = bus.in_valid;
`ifdef PIPE_ADDER_SAT_EN
            assign si_sat[k] = bus.sat;
`endif
        end else begin : g_body
            assign si_a[k] = q_a[k-1];
            assign si_b[k] = q_b[k-1];
            assign si_s[k] = q_s[k-1];
            assign si_c[k] = q_c[k-1];
            assign si_v[k] = q_v[k-1];
`ifdef PIPE_ADDER_SAT_EN
            assign si_sat[k] = q_sat[k-1];
`endif
        end

        assign add_c = {1'b0, si_a[k][k*W +: W]}
                     + {1'b0, si_b[k][k*W +: W]}
                     + (W+1)'(si_c[k]);

        // Merge this slice into the partial sum carried down the pipe
        always_comb begin
            nxt_s             = si_s[k];
            nxt_s[k*W +: W]   = add_c[W-1:0];
        end

        assign so_s[k] = nxt_s;
        assign so_c[k] = add_c[W];
    end

    // Final result: signed overflow from the effective operands, optional clamp
    always_comb begin
        res_c = so_s[L];
        ovf_c = (si_a[L][N-1] == si_b[L][N-1]) && (so_s[L][N-1] != si_a[L][N-1]);
`ifdef PIPE_ADDER_SAT_EN
        if (si_sat[L] && ovf_c) begin
            res_c = si_a[L][N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end
`endif
    end

    // Pipeline registers: shift together on advance, hold otherwise; data loads only with a valid op
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                q_v[k] <= 1'b0;
            end
            for (int k = 0; k < NQ; k++) begin
                q_a[k] <= '0;
                q_b[k] <= '0;
                q_s[k] <= '0;
                q_c[k] <= 1'b0;
`ifdef PIPE_ADDER_SAT_EN
                q_sat[k] <= 1'b0;
`endif
            end
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
        end else if (adv_c) begin
            for (int k = 0; k < STAGES; k++) begin
                q_v[k] <= si_v[k];
            end
            for (int k = 0; k < STAGES - 1; k++) begin
                if (si_v[k]) begin
                    q_a[k] <= si_a[k];
                    q_b[k] <= si_b[k];
                    q_s[k] <= so_s[k];
                    q_c[k] <= so_c[k];
`ifdef PIPE_ADDER_SAT_EN
                    q_sat[k] <= si_sat[k];
`endif
                end
            end
            if (si_v[L]) begin
                r_sum  <= res_c;
                r_cout <= so_c[L];
                r_ovf  <= ovf_c;
                r_zero <= (res_c == '0);
                r_neg  <= res_c[N-1];
            end
        end
    end

    // Outputs come straight from last-stage registers; in_ready follows advance
    assign bus.in_ready  = adv_c;
    assign bus.out_valid = q_v[L];
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;
    assign bus.zero      = r_zero;
    assign bus.neg       = r_neg;

endmodule
